// File: rtl/button_pkg.sv
// Shared definitions for button conditioning: debounce FSM state encoding
// and the millisecond-to-clock-cycle conversion.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so idle pads come out of reset in their released state.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      q_o    <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: polarity normalise, synchronise, debounce, and emit
// a one-cycle press pulse. Macro BUTTON_LONG_PRESS_EN adds long-hold detection.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 12_000_000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned LONG_MS        = 800,
  parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned CNT_MAX  = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] DB_SAT  = CNT_W'(DB_CYC);

  logic             btn_norm_c;
  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;

  assign btn_norm_c = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   (btn_norm_c),
    .q_o   (btn_s)
  );

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYC);

  logic [CNT_W-1:0] hold_q;
  logic             long_seen_q;
  logic             long_q;
  logic             holding_c;
  logic             long_hit_c;
  logic             release_done_c;

  assign holding_c      = (state_q == ST_HELD) || (state_q == ST_DB_RELEASE);
  assign long_hit_c     = holding_c && !long_seen_q && (hold_q == LONG_LAST);
  assign release_done_c = (state_q == ST_DB_RELEASE) && !btn_s && (cnt_q == DB_LAST);

  // Hold timer; a release on the same edge as the long hit counts as long.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q      <= '0;
      long_seen_q <= 1'b0;
      long_q      <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      hold_q      <= '0;
      long_seen_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_q <= long_hit_c;
      if (long_hit_c) begin
        long_seen_q <= 1'b1;
      end
      if (holding_c && (hold_q != LONG_SAT)) begin
        hold_q <= hold_q + CNT_W'(1);
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  // Debounce FSM with registered level and press pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
`ifdef BUTTON_LONG_PRESS_EN
      press_q <= release_done_c && !long_seen_q && !long_hit_c;
`else
      press_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (btn_s) begin
            state_q <= ST_DB_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!btn_s) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_HELD;
            level_q <= 1'b1;
`ifndef BUTTON_LONG_PRESS_EN
            press_q <= 1'b1;
`endif
          end else if (cnt_q != DB_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!btn_s) begin
            state_q <= ST_DB_RELEASE;
            cnt_q   <= '0;
          end
        end
        ST_DB_RELEASE: begin
          if (btn_s) begin
            state_q <= ST_HELD;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_IDLE;
            level_q <= 1'b0;
          end else if (cnt_q != DB_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: an active-high and an active-low
// instance share one stimulus stream and one behavioural debounce model.
module tb_button_conditioner;

  localparam int unsigned DB_CYC   = 4;
  localparam int unsigned LONG_CYC = 20;

  logic CLK = 1'b0;
  logic RST_N;
  logic btn_raw;
  logic raw_n;
  logic lvl_h, prs_h, lng_h;
  logic lvl_l, prs_l, lng_l;

  assign raw_n = ~btn_raw;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .BTN_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_raw),
    .btn_level(lvl_h), .press_pulse(prs_h), .long_pulse(lng_h)
  );

  button_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .BTN_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(raw_n),
    .btn_level(lvl_l), .press_pulse(prs_l), .long_pulse(lng_l)
  );

  // Model: the pad reaches the debouncer two clocks late; the accepted level
  // flips once the delayed input has disagreed with it for DB_CYC+1 samples.
  bit m_s1, m_s2, m_level, m_press, m_long;
  int m_run, m_since;
  int n_assert = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  bit prev_pulse;
  int start, lat, len;
  bit r;

  function void model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_long = 1'b0;
    m_run = 0; m_since = 0; prev_pulse = 1'b0;
  endfunction

  function void model_step();
    bit s_now;
    s_now   = m_s2;
    m_press = 1'b0;
    m_long  = 1'b0;
    if (m_level) begin
      m_since++;
`ifdef BUTTON_LONG_PRESS_EN
      if (m_since == LONG_CYC) m_long = 1'b1;
`endif
    end
    if (s_now != m_level) begin
      m_run++;
      if (m_run == DB_CYC + 1) begin
        m_run   = 0;
        m_level = s_now;
`ifdef BUTTON_LONG_PRESS_EN
        if (!s_now && m_since < LONG_CYC) m_press = 1'b1;
`else
        if (s_now) m_press = 1'b1;
`endif
        if (s_now) m_since = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level_hi", lvl_h, m_level);
    check("press_hi", prs_h, m_press);
    check("long_hi",  lng_h, m_long);
    check("level_lo", lvl_l, m_level);
    check("press_lo", prs_l, m_press);
    check("long_lo",  lng_l, m_long);
  endtask

  task automatic tick(input logic v);
    btn_raw = v;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
    check("pulse_exclusive", prs_h & lng_h, 1'b0);
    check("pulse_back_to_back", (prs_h | lng_h) & prev_pulse, 1'b0);
    prev_pulse = prs_h | lng_h;
    if (prs_h || lng_h) n_pulses++;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) tick(v);
  endtask

  initial begin
    RST_N   = 1'b0;
    btn_raw = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all();
    RST_N = 1'b1;
    hold(1'b0, 4);

    // Clean press: pulse on the 7th edge after the pad change
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      if (prs_h && lat == 0) lat = i;
    end
`ifndef BUTTON_LONG_PRESS_EN
    check_int("press_latency", lat, 7);
`endif
    check("clean_level", lvl_h, 1'b1);
    hold(1'b0, 12);

    // Short glitches never accepted
    start = n_pulses;
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 8);
    check_int("glitch_pulses", n_pulses - start, 0);
    check("glitch_level", lvl_h, 1'b0);

    // Bouncy release yields exactly one event
    start = n_pulses;
    hold(1'b1, 10);
    repeat (3) begin
      hold(1'b0, 1);
      hold(1'b1, 2);
    end
    hold(1'b0, 12);
    check_int("bounce_pulses", n_pulses - start, 1);

    // Reset while held, then re-debounce of the still-held button
    hold(1'b1, 9);
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    check_all();
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      if (prs_h && lat == 0) lat = i;
    end
`ifndef BUTTON_LONG_PRESS_EN
    check_int("reset_repress_latency", lat, 7);
`endif
    hold(1'b0, 12);

    // Long and short holds
    hold(1'b1, 30); hold(1'b0, 12);
    hold(1'b1, 8);  hold(1'b0, 12);

    // Random pad activity
    repeat (40) begin
      r   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      hold(r, len);
    end
    hold(1'b1, 26);
    hold(1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
